// File: rtl/control_gen_pipe_if.sv
// Decoder bundle interface: upstream opcode/handshake plus the registered control outputs.
// master drives opcodes and pipeline control; slave is the decoder pipeline.
interface control_gen_pipe_if #(
  parameter int CNT_W = 8
);
  logic [6:0]       opcode_in;
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic             out_valid;
  logic [1:0]       U_control;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic             alu_src;
  logic             branch;
  logic             jump;
  logic             illegal;
  logic [CNT_W-1:0] illegal_count;

  modport master (
    output opcode_in, in_valid, stall, flush,
    input  out_valid, U_control, reg_write, mem_read, mem_write,
           alu_src, branch, jump, illegal, illegal_count
  );

  modport slave (
    input  opcode_in, in_valid, stall, flush,
    output out_valid, U_control, reg_write, mem_read, mem_write,
           alu_src, branch, jump, illegal, illegal_count
  );
endinterface

// File: rtl/control_gen_pipe.sv
// RV32I opcode-to-control decoder carried through STAGES register stages with
// valid/stall/flush, plus a saturating count of illegal opcodes.
module control_gen_pipe #(
  parameter int STAGES = 1,
  parameter int CNT_W  = 8
) (
  input logic               clk,
  input logic               rst,
  control_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [1:0] u_control;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I_ALU = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("control_gen_pipe: STAGES must be in 1..4");
  end

  ctrl_t dec;

  always_comb begin
    dec = '0;
    case (bus.opcode_in)
      OP_R:     dec.reg_write = 1'b1;
      OP_I_ALU: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_LOAD:  begin
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_BR:    dec.branch = 1'b1;
      OP_JAL:   begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.u_control = 2'b10;
      end
      OP_JALR:  begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_LUI:   begin
        dec.reg_write = 1'b1;
        dec.u_control = 2'b01;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.u_control = 2'b11;
      end
      default:  dec.illegal = 1'b1;
    endcase
  end

  logic [STAGES-1:0] vld_q;
  ctrl_t             bnd_q [STAGES];
  logic [CNT_W-1:0]  cnt_q;
  logic              cap_illegal;

  assign cap_illegal = bus.in_valid & dec.illegal & ~bus.stall & ~bus.flush;

  // Flush beats stall; an idle slot always carries a zeroed bundle.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) bnd_q[k] <= '0;
    end else if (!bus.stall) begin
      vld_q[0] <= bus.in_valid;
      bnd_q[0] <= bus.in_valid ? dec : '0;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
        bnd_q[k] <= bnd_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cap_illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  ctrl_t out_b;
  assign out_b = vld_q[STAGES-1] ? bnd_q[STAGES-1] : '0;

  assign bus.out_valid     = vld_q[STAGES-1];
  assign bus.U_control     = out_b.u_control;
  assign bus.reg_write     = out_b.reg_write;
  assign bus.mem_read      = out_b.mem_read;
  assign bus.mem_write     = out_b.mem_write;
  assign bus.alu_src       = out_b.alu_src;
  assign bus.branch        = out_b.branch;
  assign bus.jump          = out_b.jump;
  assign bus.illegal       = out_b.illegal;
  assign bus.illegal_count = cnt_q;

endmodule

// File: doc/control_gen_pipe.md
Name: control_gen_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle opcode-to-control decoder.
- Decodes a 7-bit RV32I opcode into the full control bundle, including U_control for JAL, LUI and AUIPC.
- Carries the bundle through STAGES register stages with valid, stall and flush, so the same decoder serves the single-cycle core and a pipelined core.
- Flags illegal opcodes and keeps a saturating count of them.

Parameters:
- STAGES, 1, number of register stages between opcode_in and the outputs; legal range 1..4.
- CNT_W, 8, width of illegal_count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- opcode_in  in  7  opcode field of the instruction being decoded.
- in_valid  in  1  opcode_in is a real instruction this cycle.
- stall  in  1  hold every stage; no advance.
- flush  in  1  invalidate every stage.
- out_valid  out  1  output bundle is valid.
- U_control  out  2  U/J-type operand select.
- reg_write  out  1  write the register file.
- mem_read  out  1  load.
- mem_write  out  1  store.
- alu_src  out  1  ALU operand B is the immediate.
- branch  out  1  conditional branch.
- jump  out  1  JAL or JALR.
- illegal  out  1  valid opcode not in the decode table.
- illegal_count  out  CNT_W  saturating count of captured illegal opcodes.

Behaviour:
- Decode table, combinational at stage-1 input. Flags not listed are 0.
  - 0110011 R: reg_write.
  - 0010011 I-ALU: reg_write, alu_src.
  - 0000011 load: reg_write, mem_read, alu_src.
  - 0100011 store: mem_write, alu_src.
  - 1100011 branch: branch.
  - 1101111 JAL: reg_write, jump, U_control=10.
  - 1100111 JALR: reg_write, jump, alu_src.
  - 0110111 LUI: reg_write, U_control=01.
  - 0010111 AUIPC: reg_write, U_control=11.
  - U_control=00 for every opcode other than JAL, LUI and AUIPC.
  - Any other opcode: illegal=1, all other flags 0, U_control=00.
- Each stage holds a valid bit plus the decoded bundle (8 control bits + illegal).
- Advance: when stall=0 and flush=0, stage1 <= {in_valid, decode(opcode_in)} and stage k <= stage k-1.
  - in_valid=0 loads valid=0 and a zeroed bundle into stage1.
- Stall: stall=1 and flush=0 holds all stages unchanged; opcode_in is dropped, and upstream must hold it.
- Flush: flush=1 clears every valid bit and bundle next edge, regardless of stall. Flush has priority over stall.
- Latency: an opcode presented with in_valid=1 at edge n, with no stall or flush, appears at the outputs after edge n+STAGES-1. With STAGES=1 it is visible in the cycle after edge n.
- Output gating: outputs are driven from the last stage. When out_valid=0, every control output and illegal read 0.
- illegal_count increments by 1 on an edge where stage1 captures a valid illegal opcode (in_valid=1, decoded illegal, stall=0, flush=0).
  - Saturates at 2^CNT_W-1; no wrap.
  - Flushes and stalls never decrement it.
- Reset (rst=1 at an edge): all valid bits 0, all bundles 0, illegal_count 0. Rst overrides flush and stall.
  - Outputs read 0 from the cycle after that edge.
  - Reset mid-stream discards all in-flight opcodes.
- No combinational path from opcode_in to any output for any STAGES value.
- Illegal STAGES values (0, or greater than 4) are a build-time error.

Test Plan:
- Decode sweep (STAGES=1): each of the 9 opcodes with in_valid=1, then 1010100 → JAL gives U=10, reg_write=1, jump=1; LUI gives U=01; AUIPC gives U=11; store gives mem_write=1, alu_src=1; 1010100 gives illegal=1, all else 0, illegal_count=1. Every result appears one cycle later.
- Latency (STAGES=3): issue LUI, AUIPC, JAL back-to-back → out_valid rises exactly 3 edges after LUI's edge; U_control reads 01, 11, 10 on consecutive cycles.
- Stall (STAGES=2): JAL in flight, hold stall=1 for 3 cycles → outputs frozen; no new capture; JAL emerges after stall drops with total delay 2+3 edges.
- Flush vs stall: assert flush=1 and stall=1 together with 2 valid stages → next cycle out_valid=0 and all controls 0; illegal_count unchanged.
- Saturation (CNT_W=2): feed 5 valid illegal opcodes → illegal_count 1, 2, 3, 3, 3. Illegal opcodes with in_valid=0 leave it unchanged.
- Reset mid-operation: rst=1 with 3 valid stages and illegal_count=2 → next cycle out_valid=0, all outputs 0, illegal_count=0. A new opcode decodes normally afterwards.
